// File: rtl/snn_config_loader_if.sv
// Byte-serial host configuration stream feeding snn_config_loader.
// The host drives the stream; the loader only samples it.
interface snn_config_loader_if;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_data
  );

  modport slave (
    input cfg_start,
    input cfg_valid,
    input cfg_data
  );
endinterface

// File: rtl/snn_config_loader.sv
// Collects a 99-byte configuration frame into a shadow bank and commits it atomically
// to the active bank that drives the SNN; gates the network enable on a complete frame.
module snn_config_loader #(
  parameter int WEIGHT_BYTES = 32,
  parameter int DELAY_BYTES  = 64,
  parameter int FRAME_BYTES  = WEIGHT_BYTES + DELAY_BYTES + 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  snn_config_loader_if.slave         cfg,
  input  logic                       run_en,
  output logic [8*WEIGHT_BYTES-1:0]  weights,
  output logic [8*DELAY_BYTES-1:0]   delays,
  output logic [5:0]                 threshold,
  output logic [5:0]                 decay,
  output logic [5:0]                 refractory_period,
  output logic                       net_enable,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic                       cfg_overflow
);

  localparam int       BANK_BYTES = WEIGHT_BYTES + DELAY_BYTES;
  localparam logic [6:0] THR_PTR  = 7'(BANK_BYTES);
  localparam logic [6:0] DEC_PTR  = 7'(BANK_BYTES + 1);
  localparam logic [6:0] LAST_PTR = 7'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [6:0] ptr;
  logic [6:0] next_ptr;
  logic       shadow_we;
  logic       commit;
  logic       set_overflow;
  logic       clear_flags;

  // The refractory byte is always the last one, so it never needs a shadow slot:
  // it goes straight into the active bank on the commit edge.
  logic [7:0] shadow_bytes [BANK_BYTES];
  logic [5:0] shadow_threshold;
  logic [5:0] shadow_decay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // Start always wins over valid, so a restart discards the byte of that cycle.
  always_comb begin
    next_state   = state;
    next_ptr     = ptr;
    shadow_we    = 1'b0;
    commit       = 1'b0;
    set_overflow = 1'b0;
    clear_flags  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cfg.cfg_start) begin
          next_state  = LOAD;
          next_ptr    = '0;
          clear_flags = 1'b1;
        end else if (cfg.cfg_valid) begin
          set_overflow = 1'b1;
        end
      end
      LOAD: begin
        if (cfg.cfg_start) begin
          next_ptr = '0;
        end else if (cfg.cfg_valid) begin
          shadow_we = 1'b1;
          if (ptr == LAST_PTR) begin
            commit     = 1'b1;
            next_state = DONE;
            next_ptr   = '0;
          end else begin
            next_ptr = ptr + 7'd1;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_ptr   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANK_BYTES; i++) begin
        shadow_bytes[i] <= '0;
      end
      shadow_threshold <= '0;
      shadow_decay     <= '0;
    end else if (shadow_we) begin
      if (ptr < THR_PTR) begin
        shadow_bytes[ptr] <= cfg.cfg_data;
      end else if (ptr == THR_PTR) begin
        shadow_threshold <= cfg.cfg_data[5:0];
      end else if (ptr == DEC_PTR) begin
        shadow_decay <= cfg.cfg_data[5:0];
      end
    end
  end

  // The active bank only moves on the commit edge, never on a partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights           <= '0;
      delays            <= '0;
      threshold         <= '0;
      decay             <= '0;
      refractory_period <= '0;
    end else if (commit) begin
      for (int k = 0; k < WEIGHT_BYTES; k++) begin
        weights[8*k +: 8] <= shadow_bytes[k];
      end
      for (int k = 0; k < DELAY_BYTES; k++) begin
        delays[8*k +: 8] <= shadow_bytes[WEIGHT_BYTES + k];
      end
      threshold         <= shadow_threshold;
      decay             <= shadow_decay;
      refractory_period <= cfg.cfg_data[5:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_overflow <= 1'b0;
    end else begin
      cfg_busy <= (next_state == LOAD);
      if (commit) begin
        cfg_done <= 1'b1;
      end else if (clear_flags) begin
        cfg_done <= 1'b0;
      end
      if (set_overflow) begin
        cfg_overflow <= 1'b1;
      end else if (clear_flags) begin
        cfg_overflow <= 1'b0;
      end
    end
  end

  assign net_enable = run_en & cfg_done;

endmodule

// File: tb/tb_snn_config_loader.sv
// Randomised self-checking bench for snn_config_loader, compared every cycle against
// a frame-level reference model built from byte queues.
module tb_snn_config_loader;
  localparam int WB = 32;
  localparam int DB = 64;
  localparam int FB = WB + DB + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run_en = 1'b0;
  logic [255:0] weights;
  logic [511:0] delays;
  logic [5:0]   threshold;
  logic [5:0]   decay;
  logic [5:0]   refractory_period;
  logic         net_enable;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_overflow;

  snn_config_loader_if cfg_bus ();

  snn_config_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg               (cfg_bus.slave),
    .run_en            (run_en),
    .weights           (weights),
    .delays            (delays),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .net_enable        (net_enable),
    .cfg_busy          (cfg_busy),
    .cfg_done          (cfg_done),
    .cfg_overflow      (cfg_overflow)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: a frame is a queue of received bytes; 99 of them make the active bank.
  byte unsigned m_active [FB];
  byte unsigned m_frame [$];
  bit           m_loading;
  bit           m_done;
  bit           m_overflow;

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < FB; i++) m_active[i] = 8'h00;
    m_frame.delete();
    m_loading  = 1'b0;
    m_done     = 1'b0;
    m_overflow = 1'b0;
  endtask

  task automatic modelEdge(input bit start, input bit valid, input byte unsigned data);
    if (start) begin
      if (!m_loading) m_overflow = 1'b0;
      m_done    = 1'b0;
      m_loading = 1'b1;
      m_frame.delete();
    end else if (valid) begin
      if (m_loading) begin
        m_frame.push_back(data);
        if (m_frame.size() == FB) begin
          for (int i = 0; i < FB; i++) m_active[i] = m_frame[i];
          m_frame.delete();
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end else begin
        m_overflow = 1'b1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    logic [255:0] exp_w;
    logic [511:0] exp_d;
    for (int k = 0; k < WB; k++) exp_w[8*k +: 8] = m_active[k];
    for (int k = 0; k < DB; k++) exp_d[8*k +: 8] = m_active[WB + k];
    checkOutput({tag, ".weights"}, 512'(weights), 512'(exp_w));
    checkOutput({tag, ".delays"}, delays, exp_d);
    checkOutput({tag, ".threshold"}, 512'(threshold), 512'(m_active[WB + DB] & 8'h3F));
    checkOutput({tag, ".decay"}, 512'(decay), 512'(m_active[WB + DB + 1] & 8'h3F));
    checkOutput({tag, ".refractory"}, 512'(refractory_period), 512'(m_active[FB - 1] & 8'h3F));
    checkOutput({tag, ".cfg_done"}, 512'(cfg_done), 512'(m_done));
    checkOutput({tag, ".cfg_busy"}, 512'(cfg_busy), 512'(m_loading));
    checkOutput({tag, ".cfg_overflow"}, 512'(cfg_overflow), 512'(m_overflow));
    checkOutput({tag, ".net_enable"}, 512'(net_enable), 512'(run_en & m_done));
  endtask

  // Drives one cycle of the host stream, advances the model on the same edge, checks after it.
  task automatic applyStimulus(input bit start, input bit valid, input byte unsigned data,
                               input string tag);
    cfg_bus.cfg_start = start;
    cfg_bus.cfg_valid = valid;
    cfg_bus.cfg_data  = data;
    @(posedge clk);
    modelEdge(start, valid, data);
    #1;
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = 8'h00;
    checkAll(tag);
  endtask

  task automatic sendFrame(input byte unsigned data [FB], input int max_gap, input string tag);
    applyStimulus(1'b1, 1'b0, 8'h00, tag);
    for (int k = 0; k < FB; k++) begin
      if (k > 0 && max_gap > 0) begin
        int gap = $urandom_range(max_gap, 0);
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'h00, tag);
      end
      applyStimulus(1'b0, 1'b1, data[k], tag);
    end
  endtask

  byte unsigned frame [FB];

  initial begin
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame with byte k = k
    run_en = 1'b1;
    for (int k = 0; k < FB; k++) frame[k] = 8'(k);
    sendFrame(frame, 0, "full");
    checkOutput("full.w_lo", 512'(weights[7:0]), 512'(8'h00));
    checkOutput("full.w_hi", 512'(weights[255:248]), 512'(8'h1F));
    checkOutput("full.d_lo", 512'(delays[7:0]), 512'(8'h20));
    checkOutput("full.d_hi", 512'(delays[511:504]), 512'(8'h5F));
    checkOutput("full.thr", 512'(threshold), 512'(6'h20));
    checkOutput("full.dec", 512'(decay), 512'(6'h21));
    checkOutput("full.ref", 512'(refractory_period), 512'(6'h22));
    checkOutput("full.net_en", 512'(net_enable), 512'(1'b1));

    // Atomicity: a partial frame must not disturb the committed one
    for (int k = 0; k < FB; k++) frame[k] = 8'hFF;
    sendFrame(frame, 0, "frameA");
    applyStimulus(1'b1, 1'b0, 8'h00, "frameB");
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b1, 8'h00, "frameB");
    checkOutput("atomic.w", 512'(weights), 512'({256{1'b1}}));
    checkOutput("atomic.d", delays, {512{1'b1}});
    checkOutput("atomic.thr", 512'(threshold), 512'(6'h3F));
    checkOutput("atomic.done", 512'(cfg_done), 512'(1'b0));
    checkOutput("atomic.net_en", 512'(net_enable), 512'(1'b0));

    // Restart mid-frame, start coinciding with a valid byte
    applyStimulus(1'b1, 1'b0, 8'h00, "restart");
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 8'hAA, "restart");
    applyStimulus(1'b1, 1'b1, 8'h11, "restart");
    for (int k = 0; k < FB; k++) applyStimulus(1'b0, 1'b1, 8'h55, "restart");
    checkOutput("restart.w", 512'(weights), 512'({32{8'h55}}));
    checkOutput("restart.d", delays, {64{8'h55}});
    checkOutput("restart.thr", 512'(threshold), 512'(6'h15));
    checkOutput("restart.ref", 512'(refractory_period), 512'(6'h15));

    // Overflow after DONE, cleared by the next start
    applyStimulus(1'b0, 1'b1, 8'h77, "overflow");
    checkOutput("overflow.set", 512'(cfg_overflow), 512'(1'b1));
    checkOutput("overflow.keep_w", 512'(weights), 512'({32{8'h55}}));
    applyStimulus(1'b1, 1'b0, 8'h00, "overflow_clr");
    checkOutput("overflow.clr", 512'(cfg_overflow), 512'(1'b0));

    // Async reset between edges after 60 bytes
    for (int k = 0; k < 60; k++) applyStimulus(1'b0, 1'b1, 8'($urandom), "pre_reset");
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    checkOutput("async_reset.w", 512'(weights), 512'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < FB; k++) frame[k] = 8'($urandom);
    sendFrame(frame, 0, "post_reset");
    checkOutput("post_reset.done", 512'(cfg_done), 512'(1'b1));

    // Gapped vs gapless load of the same data
    for (int k = 0; k < FB; k++) frame[k] = 8'($urandom);
    sendFrame(frame, 0, "gapless");
    sendFrame(frame, 5, "gapped");
    checkOutput("gapped.thr", 512'(threshold), 512'(frame[WB + DB] & 8'h3F));

    // Random traffic, including overflow and restarts
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99, 0) < 5) run_en = ~run_en;
      applyStimulus($urandom_range(199, 0) < 3, $urandom_range(9, 0) < 8, 8'($urandom),
                    "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/snn_config_loader.md
# snn_config_loader

Byte-serial configuration loader that sits directly upstream of the SNN top, turning a narrow 8-bit host stream into the wide parallel weights, delays, threshold, decay and refractory-period buses the network consumes. Bytes land in a shadow bank. The active bank driving the network is updated atomically only when a complete frame has arrived, so the network never runs on a partial configuration. It also gates the network enable until a valid configuration is in place.

## Interface
- WEIGHT_BYTES, 32, bytes of packed 2-bit weights (256 bits: layer-1 then layer-2)
- DELAY_BYTES, 64, bytes of packed 4-bit delay fields (512 bits: layer-1 then layer-2)
- FRAME_BYTES, WEIGHT_BYTES+DELAY_BYTES+3, total bytes per configuration frame (99)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  single-cycle pulse; begins/restarts a frame at byte 0
- cfg_valid  in  1  cfg_data holds a byte this cycle
- cfg_data  in  8  configuration byte
- run_en  in  1  host request to run the network
- weights  out  8*WEIGHT_BYTES  active weights
- delays  out  8*DELAY_BYTES  active delay fields
- threshold  out  6  active threshold
- decay  out  6  active decay
- refractory_period  out  6  active refractory period
- net_enable  out  1  enable to the network: run_en AND cfg_done
- cfg_busy  out  1  high while in LOAD
- cfg_done  out  1  high when the active bank holds a complete frame
- cfg_overflow  out  1  sticky flag: a byte arrived outside LOAD

## Operation
- States: IDLE (after reset), LOAD, DONE.
- Byte pointer `ptr` is 7 bits and counts 0..FRAME_BYTES-1.
- Byte map:
  - ptr 0..31 → weights[8k+7:8k]
  - ptr 32..95 → delays[8(k-32)+7:8(k-32)]
  - ptr 96 → threshold
  - ptr 97 → decay
  - ptr 98 → refractory_period
  - For ptr 96..98 only cfg_data[5:0] is used; bits [7:6] are ignored.
- IDLE/DONE + cfg_start:
  - go to LOAD, set ptr=0.
  - Clear cfg_done and cfg_overflow.
  - The active bank keeps its previous contents.
- LOAD + cfg_valid:
  - Write cfg_data to the shadow byte at ptr, then ptr++.
  - On the byte at ptr=FRAME_BYTES-1, on the same edge:
    - copy shadow (including this byte) into the active bank;
    - set cfg_done=1 and go to DONE;
    - set ptr=0.
- LOAD + cfg_start (with or without cfg_valid): set ptr=0 and discard that cycle's byte. Start has priority over valid.
- IDLE/DONE + cfg_valid without cfg_start: ignore the byte and set cfg_overflow=1.
- cfg_done is cleared while reloading, so net_enable drops during the reload. The old active config stays visible on the outputs.
- net_enable is combinational: run_en & cfg_done.
- Reset (any time, including mid-frame):
  - state=IDLE, ptr=0.
  - Shadow and active banks are all zero.
  - cfg_done=0, cfg_busy=0, cfg_overflow=0, net_enable=0.

## Timing
- One byte accepted per cycle when cfg_valid=1 in LOAD; there is no backpressure.
- cfg_busy is registered: it is 1 in the cycle after cfg_start and stays 1 through the cycle the last byte is sampled.
- Outputs change on the rising edge that samples the last byte. cfg_done=1 and the new outputs are visible one clk after the last byte is presented.
- Minimum frame time: 1 cycle (start) + 99 cycles (bytes). Back-to-back valid bytes are allowed; gaps of any length are allowed.
- The active bank changes only on the frame-completion edge and on reset. No other edge alters weights, delays, threshold, decay or refractory_period.

## Test plan
- Full frame:
  - Stimulus: pulse start, then 99 consecutive bytes with byte k = k.
  - Required: weights[7:0]=0x00, weights[255:248]=0x1F, delays[7:0]=0x20, delays[511:504]=0x5F, threshold=0x20 (0x60 masked), decay=0x21, refractory_period=0x22, cfg_done=1.
  - With run_en=1: net_enable=1 the cycle after the last byte.
- Atomicity:
  - Stimulus: load frame A (all 0xFF), then start frame B (all 0x00) and stop after 50 bytes.
  - Required: weights/delays stay all-ones and threshold stays 0x3F; cfg_done=0, net_enable=0.
- Restart mid-frame:
  - Stimulus: send 40 bytes of 0xAA, pulse start together with a valid byte 0x11, then 99 bytes of 0x55.
  - Required: outputs are all 0x55 patterns (threshold 0x15); no 0xAA or 0x11 appears.
- Overflow:
  - Stimulus: after DONE, assert cfg_valid with 0x77.
  - Required: cfg_overflow=1, outputs unchanged. A following cfg_start clears cfg_overflow.
- Async reset mid-frame:
  - Stimulus: drop rst_n between clock edges after 60 bytes.
  - Required: all outputs 0 immediately; a fresh 99-byte frame after release completes normally.
- Gapped stream:
  - Stimulus: a full frame with random 0–5 idle cycles between bytes.
  - Required: final outputs identical to the gapless load of the same data.
